// File: rtl/winner_policy_param.sv
// winner_policy_param
//   Chooses the next hop for one routing decision. The block makes an
//   epsilon-greedy choice:
//   - Explore: the draw is below epsilon. The block reads the neighbour count
//     from memory and reduces the seed modulo that count by repeated
//     subtraction. It then reads that neighbour's entry as the next hop and
//     decays epsilon.
//   - Exploit: the block compares the best neighbour value against this
//     node's own best, using a hysteresis band, and adopts besthop only when
//     the comparison says the move is worthwhile.
//
// Ports
//   clock, rst        sole clock (rising edge), synchronous active-high reset
//   start             request one decision (accepted only when idle)
//   mybest, bestvalue, besthop, bestneighbor_id, my_node_id
//                     decision operands, latched on an accepted start
//   epsilon_init      epsilon value loaded during reset
//   epsilon_step      decay applied after each explore decision
//   rng_in            random word: low RNG_WIDTH bits = draw, next IDX_BITS = seed
//   mem_addr, mem_rd  read request to memory
//   mem_data          read data, valid MEM_LAT cycles after the request
//   nexthop, epsilon, explored
//                     decision results, held until the next decision
//   busy, done        busy while a decision runs; done pulses once at its end
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for start
// S_DRAW     | compare the latched draw with epsilon
// S_RD_CNT   | issue the neighbour-count read
// S_WAIT_CNT | wait out the read latency, then capture and clip the count
// S_MOD      | reduce the seed modulo the count, one subtraction per cycle
// S_RD_NB    | issue the neighbour-table read
// S_WAIT_NB  | wait out the read latency, capture the next hop, decay epsilon
// S_CMP1     | exploit: bestvalue < mybest*LOW_Q ?
// S_CMP2     | exploit: bestvalue < mybest*HIGH_Q, and the best neighbour is not us ?
// S_DONE     | one-cycle done pulse
module winner_policy_param #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    RNG_WIDTH  = 4,
  parameter int                    MAX_NB     = 16,
  parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR = 16'h068C,
  parameter logic [ADDR_WIDTH-1:0] NB_BASE    = 16'h0668,
  parameter int                    NB_STRIDE  = 2,
  parameter int                    MEM_LAT    = 1,
  parameter logic [WORD_WIDTH-1:0] NO_HOP     = 16'd100,
  parameter logic [WORD_WIDTH-1:0] LOW_Q      = 16'hFFBE,
  parameter logic [WORD_WIDTH-1:0] HIGH_Q     = 16'h8020
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] bestvalue,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] bestneighbor_id,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] epsilon_init,
  input  logic [WORD_WIDTH-1:0] epsilon_step,
  input  logic [WORD_WIDTH-1:0] rng_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic [WORD_WIDTH-1:0] epsilon,
  output logic                  explored,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_BITS = $clog2(MAX_NB);
  localparam int CNT_BITS = IDX_BITS + 1;          // must hold MAX_NB itself
  localparam int LAT_BITS = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int PW       = 2 * WORD_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DRAW     = 4'd1,
    S_RD_CNT   = 4'd2,
    S_WAIT_CNT = 4'd3,
    S_MOD      = 4'd4,
    S_RD_NB    = 4'd5,
    S_WAIT_NB  = 4'd6,
    S_CMP1     = 4'd7,
    S_CMP2     = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [RNG_WIDTH-1:0]  draw_q, draw_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic [LAT_BITS-1:0]   lat_q, lat_d;
  logic [WORD_WIDTH-1:0] mybest_q, mybest_d;
  logic [WORD_WIDTH-1:0] bestvalue_q, bestvalue_d;
  logic [WORD_WIDTH-1:0] besthop_q, besthop_d;
  logic [WORD_WIDTH-1:0] nb_id_q, nb_id_d;
  logic [WORD_WIDTH-1:0] my_id_q, my_id_d;
  logic [WORD_WIDTH-1:0] step_q, step_d;
  logic [WORD_WIDTH-1:0] nexthop_q, nexthop_d;
  logic [WORD_WIDTH-1:0] epsilon_q, epsilon_d;
  logic                  explored_q, explored_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  // ---------------------------------------------------------------------
  // Shared decision terms
  // ---------------------------------------------------------------------
  logic                  draw_hit;
  logic                  lat_zero;
  logic                  cnt_zero;
  logic [CNT_BITS-1:0]   cnt_clip;
  logic                  mod_ge;
  logic [IDX_BITS-1:0]   mod_sub;
  logic                  mod_last;
  logic [PW-1:0]         left_p;
  logic [PW-1:0]         right_low;
  logic [PW:0]           right_high;
  logic                  lt_low;
  logic                  lt_high;
  logic [ADDR_WIDTH-1:0] nb_addr;
  logic                  unused_rng;

  assign unused_rng = ^rng_in[WORD_WIDTH-1:RNG_WIDTH+IDX_BITS];

  assign draw_hit = WORD_WIDTH'(draw_q) < epsilon_q;
  assign lat_zero = (lat_q == '0);

  // Counts larger than the table are treated as a full table.
  assign cnt_zero = (mem_data == '0);
  assign cnt_clip = (mem_data > WORD_WIDTH'(MAX_NB)) ? CNT_BITS'(MAX_NB)
                                                     : CNT_BITS'(mem_data);

  // mod_last means this subtraction already brings idx below count, so
  // the reduction can leave without spending an extra cycle on the final compare.
  assign mod_ge   = ({1'b0, idx_q} >= count_q);
  assign mod_sub  = IDX_BITS'({1'b0, idx_q} - count_q);
  assign mod_last = ({1'b0, mod_sub} < count_q);

  // Products are kept full width. right_high gets one extra bit so that
  // mybest*HIGH_Q + mybest<<15 cannot wrap for large mybest.
  assign left_p     = {bestvalue_q, {WORD_WIDTH{1'b0}}};
  assign right_low  = PW'(mybest_q) * PW'(LOW_Q);
  assign right_high = (PW+1)'(mybest_q) * (PW+1)'(HIGH_Q)
                    + ((PW+1)'(mybest_q) << (WORD_WIDTH - 1));
  assign lt_low     = left_p < right_low;
  assign lt_high    = {1'b0, left_p} < right_high;

  assign nb_addr = NB_BASE + ADDR_WIDTH'(idx_d) * ADDR_WIDTH'(NB_STRIDE);

  // ---------------------------------------------------------------------
  // State register and datapath flops
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      draw_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      lat_q       <= '0;
      mybest_q    <= '0;
      bestvalue_q <= '0;
      besthop_q   <= '0;
      nb_id_q     <= '0;
      my_id_q     <= '0;
      step_q      <= '0;
      nexthop_q   <= NO_HOP;
      epsilon_q   <= epsilon_init;
      explored_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      draw_q      <= draw_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      lat_q       <= lat_d;
      mybest_q    <= mybest_d;
      bestvalue_q <= bestvalue_d;
      besthop_q   <= besthop_d;
      nb_id_q     <= nb_id_d;
      my_id_q     <= my_id_d;
      step_q      <= step_d;
      nexthop_q   <= nexthop_d;
      epsilon_q   <= epsilon_d;
      explored_q  <= explored_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_DRAW;
      S_DRAW:     state_d = draw_hit ? S_RD_CNT : S_CMP1;
      S_RD_CNT:   state_d = S_WAIT_CNT;
      S_WAIT_CNT: if (lat_zero) state_d = cnt_zero ? S_CMP1 : S_MOD;
      S_MOD:      if (!mod_ge || mod_last) state_d = S_RD_NB;
      S_RD_NB:    state_d = S_WAIT_NB;
      S_WAIT_NB:  if (lat_zero) state_d = S_DONE;
      S_CMP1:     state_d = lt_low ? S_DONE : S_CMP2;
      S_CMP2:     state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    draw_d      = draw_q;
    idx_d       = idx_q;
    count_d     = count_q;
    lat_d       = lat_q;
    mybest_d    = mybest_q;
    bestvalue_d = bestvalue_q;
    besthop_d   = besthop_q;
    nb_id_d     = nb_id_q;
    my_id_d     = my_id_q;
    step_d      = step_q;
    nexthop_d   = nexthop_q;
    epsilon_d   = epsilon_q;
    explored_d  = explored_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          draw_d      = rng_in[RNG_WIDTH-1:0];
          idx_d       = rng_in[RNG_WIDTH +: IDX_BITS];
          mybest_d    = mybest;
          bestvalue_d = bestvalue;
          besthop_d   = besthop;
          nb_id_d     = bestneighbor_id;
          my_id_d     = my_node_id;
          step_d      = epsilon_step;
        end
      end
      // The timer is loaded here so that the first wait cycle already
      // holds MEM_LAT-1. Data is then captured on the MEM_LAT-th edge
      // after the request.
      S_RD_CNT, S_RD_NB: lat_d = LAT_BITS'(MEM_LAT - 1);
      S_WAIT_CNT: begin
        if (lat_zero) count_d = cnt_clip;
        else          lat_d   = lat_q - LAT_BITS'(1);
      end
      S_MOD: begin
        if (mod_ge) idx_d = mod_sub;
      end
      S_WAIT_NB: begin
        if (lat_zero) begin
          nexthop_d  = mem_data;
          explored_d = 1'b1;
          epsilon_d  = (epsilon_q > step_q) ? (epsilon_q - step_q) : '0;
        end else begin
          lat_d = lat_q - LAT_BITS'(1);
        end
      end
      S_CMP1: begin
        explored_d = 1'b0;
        if (lt_low) nexthop_d = besthop_q;
      end
      S_CMP2: begin
        if (lt_high && (nb_id_q != my_id_q)) nexthop_d = besthop_q;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state. They are therefore registered,
  // yet they still line up with the state they describe.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    mem_rd_d   = (state_d == S_RD_CNT) || (state_d == S_RD_NB);
    mem_addr_d = mem_addr_q;
    if (state_d == S_RD_CNT)     mem_addr_d = COUNT_ADDR;
    else if (state_d == S_RD_NB) mem_addr_d = nb_addr;
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign nexthop  = nexthop_q;
  assign epsilon  = epsilon_q;
  assign explored = explored_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_winner_policy_param.sv
module tb_winner_policy_param;

  localparam int          LAT      = 3;
  localparam logic [15:0] CNT_A    = 16'h068C;
  localparam logic [15:0] NB_A     = 16'h0668;
  localparam longint      LOW_QV   = 64'hFFBE;
  localparam longint      HIGH_QV  = 64'h8020;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mybest = '0, bestvalue = '0, besthop = '0;
  logic [15:0] bestneighbor_id = '0, my_node_id = '0;
  logic [15:0] epsilon_init = '0, epsilon_step = '0, rng_in = '0;
  logic [15:0] mem_addr, mem_data, nexthop, epsilon;
  logic        mem_rd, explored, busy, done;

  always #5 clock = ~clock;

  winner_policy_param #(.MEM_LAT(LAT)) dut (
    .clock(clock), .rst(rst), .start(start),
    .mybest(mybest), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighbor_id(bestneighbor_id), .my_node_id(my_node_id),
    .epsilon_init(epsilon_init), .epsilon_step(epsilon_step), .rng_in(rng_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .nexthop(nexthop), .epsilon(epsilon), .explored(explored),
    .busy(busy), .done(done)
  );

  // Memory model: data appears exactly LAT cycles after the request. At
  // any other time the bus carries junk.
  logic [15:0]    mem [0:65535];
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  logic [15:0]    junk = 16'h5A5A;

  always @(posedge clock) begin
    pv    <= {pv[LAT-2:0], mem_rd};
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    junk  <= 16'($urandom);
  end
  assign mem_data = pv[LAT-1] ? mem[pa[LAT-1]] : junk;

  // Scoreboard
  typedef struct packed {
    logic [15:0] nh;
    logic [15:0] eps;
    logic        ex;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  exp_t        mon_e;
  int          n_chk = 0, n_fail = 0, done_cnt = 0;
  bit          prev_done = 0;
  longint      model_eps = 0, model_nh = 100;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clock) begin
    if (rst) begin
      prev_done = 0;
    end else begin
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
      end
      if (done) begin
        done_cnt++;
        chk("busy_in_done", busy, 1);
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          mon_e = exp_q.pop_front();
          chk("nexthop", nexthop, mon_e.nh);
          chk("epsilon", epsilon, mon_e.eps);
          chk("explored", explored, mon_e.ex);
        end
      end
      if (mem_rd) begin
        if (addr_q.size() == 0) fail_now("unexpected_mem_rd");
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      prev_done = done;
    end
  end

  // Reference model: epsilon-greedy rule written as plain arithmetic.
  task automatic push_expect(input logic [15:0] rng, mb, bv, bh, bnid, myid, step);
    longint draw, seed, cnt, idx, a, left, r1, r3;
    exp_t   e;
    bit     do_exploit;
    draw = longint'(rng) % 16;
    seed = (longint'(rng) / 16) % 16;
    do_exploit = 1;
    if (draw < model_eps) begin
      addr_q.push_back(CNT_A);
      cnt = longint'(mem[CNT_A]);
      if (cnt > 16) cnt = 16;
      if (cnt != 0) begin
        do_exploit = 0;
        idx = seed % cnt;
        a = (longint'(NB_A) + idx * 2) % 65536;
        addr_q.push_back(16'(a));
        model_nh  = longint'(mem[16'(a)]);
        model_eps = (model_eps > longint'(step)) ? model_eps - longint'(step) : 0;
        e.ex = 1'b1;
      end
    end
    if (do_exploit) begin
      left = longint'(bv) * 65536;
      r1   = longint'(mb) * LOW_QV;
      r3   = longint'(mb) * HIGH_QV + longint'(mb) * 32768;
      if (left < r1) model_nh = longint'(bh);
      else if (left < r3 && bnid != myid) model_nh = longint'(bh);
      e.ex = 1'b0;
    end
    e.nh  = 16'(model_nh);
    e.eps = 16'(model_eps);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [15:0] einit);
    @(negedge clock);
    rst = 1'b1;
    start = 1'b0;
    epsilon_init = einit;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    model_eps = longint'(einit);
    model_nh  = 100;
  endtask

  task automatic fill_mem(input logic [15:0] cnt_word);
    mem[CNT_A] = cnt_word;
    for (int i = 0; i < 16; i++) mem[NB_A + 16'(2*i)] = 16'($urandom);
  endtask

  task automatic decide(input logic [15:0] rng, mb, bv, bh, bnid, myid, step,
                        input bit hold);
    int t;
    @(negedge clock);
    rng_in = rng; mybest = mb; bestvalue = bv; besthop = bh;
    bestneighbor_id = bnid; my_node_id = myid; epsilon_step = step;
    push_expect(rng, mb, bv, bh, bnid, myid, step);
    start = 1'b1;
    @(negedge clock);
    if (!hold) start = 1'b0;
    // Operands must have been latched; scramble the inputs.
    rng_in = 16'($urandom); mybest = 16'($urandom); bestvalue = 16'($urandom);
    besthop = 16'($urandom); epsilon_step = 16'($urandom);
    t = 0;
    while (!done && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) begin
      fail_now("done_timeout");
      exp_q.delete();
      addr_q.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t;
    logic [15:0] mb, bv, id;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Reset values
    do_reset(16'd8);
    chk("rst_nexthop", nexthop, 100);
    chk("rst_epsilon", epsilon, 8);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_explored", explored, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Explore: seed 12 mod 5 = 2, table entry at 0x66C
    fill_mem(16'd5);
    mem[16'h066C] = 16'd7;
    d0 = done_cnt;
    decide(16'h00C3, 16'h0640, 16'h0600, 16'd3, 16'd1, 16'd2, 16'd2, 0);
    repeat (3) @(negedge clock);
    chk("dir_explore_nh", nexthop, 7);
    chk("dir_explore_eps", epsilon, 6);
    chk("dir_explore_ex", explored, 1);
    chk("dir_explore_done_count", done_cnt - d0, 1);

    // Exploit through CMP1
    decide(16'h000F, 16'h0640, 16'h0600, 16'd3, 16'd1, 16'd2, 16'd2, 0);
    chk("dir_cmp1_nh", nexthop, 3);
    chk("dir_cmp1_ex", explored, 0);
    chk("dir_cmp1_eps", epsilon, 6);

    // Exploit through CMP2: ids differ -> take, ids equal -> hold
    decide(16'h000F, 16'h0640, 16'h0640, 16'd4, 16'd5, 16'd6, 16'd2, 0);
    chk("dir_cmp2_take", nexthop, 4);
    decide(16'h000F, 16'h0640, 16'h0640, 16'd9, 16'd7, 16'd7, 16'd2, 0);
    chk("dir_cmp2_hold", nexthop, 4);

    // Epsilon saturates at zero
    do_reset(16'd1);
    fill_mem(16'd3);
    decide(16'h0000, 16'h0100, 16'h0100, 16'd5, 16'd1, 16'd1, 16'd2, 0);
    chk("dir_eps_sat", epsilon, 0);

    // Count 0 falls back to exploit
    do_reset(16'd8);
    fill_mem(16'd0);
    decide(16'h0001, 16'h0640, 16'h0600, 16'd11, 16'd1, 16'd2, 16'd3, 0);
    chk("dir_cnt0_nh", nexthop, 11);
    chk("dir_cnt0_eps", epsilon, 8);
    chk("dir_cnt0_ex", explored, 0);

    // Random decisions
    for (int k = 0; k < 150; k++) begin
      if (k % 25 == 0) do_reset(16'($urandom_range(0, 15)));
      fill_mem((k % 5 == 0) ? 16'($urandom) : 16'($urandom_range(0, 20)));
      mb = 16'($urandom);
      bv = (k % 2 == 0) ? 16'(mb + 16'($urandom_range(0, 8)) - 16'd4) : 16'($urandom);
      id = 16'($urandom_range(0, 3));
      decide(16'($urandom), mb, bv, 16'($urandom), id,
             16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 0);
    end

    // Reset during WAIT_NB aborts without a done pulse
    do_reset(16'd12);
    fill_mem(16'd9);
    @(negedge clock);
    rng_in = 16'h0052; mybest = 16'h0640; bestvalue = 16'h0600; besthop = 16'd3;
    bestneighbor_id = 16'd1; my_node_id = 16'd2; epsilon_step = 16'd1;
    push_expect(16'h0052, 16'h0640, 16'h0600, 16'd3, 16'd1, 16'd2, 16'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0;
    while (!(mem_rd && mem_addr != CNT_A) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) fail_now("nb_read_timeout");
    d0 = done_cnt;
    do_reset(16'd12);
    chk("abort_nexthop", nexthop, 100);
    chk("abort_epsilon", epsilon, 12);
    chk("abort_busy", busy, 0);
    chk("abort_explored", explored, 0);
    repeat (10) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);

    // Start held high through the whole decision -> exactly one done
    fill_mem(16'd4);
    d0 = done_cnt;
    decide(16'h0031, 16'h0200, 16'h0100, 16'd21, 16'd1, 16'd2, 16'd1, 1);
    repeat (10) @(negedge clock);
    chk("held_start_one_done", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
